// File: rtl/risky_pkg.sv
// ----------------------------------------------------------------------------
// risky_pkg
// Shared definitions for the risky core pipeline:
//   opcode_e    - instr[6:2] major opcodes
//   F3_*        - funct3 encodings for loads
//   wb_state_e  - writeback stage FSM states
// ----------------------------------------------------------------------------
package risky_pkg;

    typedef enum logic [4:0] {
        OP_LOAD   = 5'b00000,
        OP_OP_IMM = 5'b00100,
        OP_AUIPC  = 5'b00101,
        OP_STORE  = 5'b01000,
        OP_OP     = 5'b01100,
        OP_LUI    = 5'b01101,
        OP_BRANCH = 5'b11000,
        OP_JALR   = 5'b11001,
        OP_JAL    = 5'b11011,
        OP_SYSTEM = 5'b11100
    } opcode_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// ----------------------------------------------------------------------------
// load_align
// Combinational load data alignment and extension.
// Ports:
//   word_i        raw 32-bit word read from data memory
//   addr_i        low two bits of the load address
//   funct3_i      load size/sign (LB/LH/LW/LBU/LHU; reserved codes act as LW)
//   data_o        aligned, extended load value
//   misaligned_o  access crosses its natural alignment (LH/LHU odd, LW not /4)
// ----------------------------------------------------------------------------
module load_align
    import risky_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Shift the addressed lane down to bit 0; truncation keeps only that lane.
    assign byte_v = 8'(word_i >> {addr_i, 3'b000});
    assign half_v = 16'(word_i >> {addr_i[1], 4'b0000});

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        data_o       = word_i;
        misaligned_o = (addr_i != 2'b00);
        case (funct3_i)
            F3_LB: begin
                data_o       = {{24{byte_v[7]}}, byte_v};
                misaligned_o = 1'b0;
            end
            F3_LBU: begin
                data_o       = {24'h0, byte_v};
                misaligned_o = 1'b0;
            end
            F3_LH: begin
                data_o       = {{16{half_v[15]}}, half_v};
                misaligned_o = addr_i[0];
            end
            F3_LHU: begin
                data_o       = {16'h0, half_v};
                misaligned_o = addr_i[0];
            end
            F3_LW: begin
                data_o       = word_i;
                misaligned_o = (addr_i != 2'b00);
            end
            default: begin
                data_o       = word_i;
                misaligned_o = (addr_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/writeback.sv
// ----------------------------------------------------------------------------
// writeback
// Fifth pipeline stage: selects the result source, aligns load data, drives
// the regfile write port and stalls upstream while a load waits for memory.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   valid_i / ready_o   upstream handshake (ready_o = FSM idle)
//   opcode_i, funct3_i  instruction class and load size/sign
//   rd_i                destination register
//   alu_result_i        ALU result / load address
//   pc_plus4_i          link value for JAL/JALR
//   mem_valid_i/data_i  load response (sampled only while waiting)
//   rf_we_o/sel_rd_o/rd_o  regfile write port, one-cycle commit
//   retire_o            one-cycle pulse per committed instruction
//   misaligned_o        one-cycle pulse when a misaligned load is dropped
//   instret_o           retired-instruction count
// Configuration:
//   WB_RETIRE_CNT_EN    defined: instret_o counts retire_o pulses (wrapping);
//                       undefined: no counter, instret_o tied to 0.
// ----------------------------------------------------------------------------
module writeback
    import risky_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [4:0]           opcode_i,
    input  logic [2:0]           funct3_i,
    input  logic [4:0]           rd_i,
    input  logic [XLEN-1:0]      alu_result_i,
    input  logic [XLEN-1:0]      pc_plus4_i,
    input  logic                 mem_valid_i,
    input  logic [XLEN-1:0]      mem_data_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_sel_rd_o,
    output logic [XLEN-1:0]      rf_rd_o,
    output logic                 retire_o,
    output logic                 misaligned_o,
    output logic [CNT_WIDTH-1:0] instret_o
);

    wb_state_e       state_q, state_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic [2:0]      ld_funct3_q, ld_funct3_d;
    logic [1:0]      ld_addr_q, ld_addr_d;

    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_sel_rd_q, rf_sel_rd_d;
    logic [XLEN-1:0] rf_rd_q, rf_rd_d;
    logic            retire_q, retire_d;
    logic            misaligned_q, misaligned_d;

    logic [XLEN-1:0] align_data;
    logic            align_misaligned;

    // Alignment works on the latched load attributes, not the live inputs,
    // because upstream may already present the next instruction.
    load_align u_load_align (
        .word_i       (mem_data_i),
        .addr_i       (ld_addr_q),
        .funct3_i     (ld_funct3_q),
        .data_o       (align_data),
        .misaligned_o (align_misaligned)
    );

    assign ready_o = (state_q == WB_IDLE);

    always_comb begin
        state_d      = state_q;
        ld_rd_d      = ld_rd_q;
        ld_funct3_d  = ld_funct3_q;
        ld_addr_d    = ld_addr_q;
        rf_we_d      = 1'b0;
        rf_sel_rd_d  = rf_sel_rd_q;
        rf_rd_d      = rf_rd_q;
        retire_d     = 1'b0;
        misaligned_d = 1'b0;

        case (state_q)
            WB_IDLE: begin
                if (valid_i) begin
                    if (opcode_i == OP_LOAD) begin
                        ld_rd_d     = rd_i;
                        ld_funct3_d = funct3_i;
                        ld_addr_d   = alu_result_i[1:0];
                        state_d     = WB_WAIT_MEM;
                    end else begin
                        retire_d = 1'b1;
                        case (opcode_i)
                            OP_OP, OP_OP_IMM, OP_LUI, OP_AUIPC: begin
                                rf_we_d     = (rd_i != 5'd0);
                                rf_sel_rd_d = rd_i;
                                rf_rd_d     = alu_result_i;
                            end
                            OP_JAL, OP_JALR: begin
                                rf_we_d     = (rd_i != 5'd0);
                                rf_sel_rd_d = rd_i;
                                rf_rd_d     = pc_plus4_i;
                            end
                            // Stores, branches, system and unknown opcodes
                            // retire without touching the regfile.
                            OP_STORE, OP_BRANCH, OP_SYSTEM: ;
                            default: ;
                        endcase
                    end
                end
            end
            WB_WAIT_MEM: begin
                if (mem_valid_i) begin
                    state_d = WB_IDLE;
                    if (align_misaligned) begin
                        misaligned_d = 1'b1;
                    end else begin
                        retire_d    = 1'b1;
                        rf_we_d     = (ld_rd_q != 5'd0);
                        rf_sel_rd_d = ld_rd_q;
                        rf_rd_d     = align_data;
                    end
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all next-state
    // logic lives in the always_comb above with blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WB_IDLE;
            ld_rd_q      <= 5'd0;
            ld_funct3_q  <= 3'd0;
            ld_addr_q    <= 2'd0;
            rf_we_q      <= 1'b0;
            rf_sel_rd_q  <= 5'd0;
            rf_rd_q      <= '0;
            retire_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_rd_q      <= ld_rd_d;
            ld_funct3_q  <= ld_funct3_d;
            ld_addr_q    <= ld_addr_d;
            rf_we_q      <= rf_we_d;
            rf_sel_rd_q  <= rf_sel_rd_d;
            rf_rd_q      <= rf_rd_d;
            retire_q     <= retire_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign rf_we_o      = rf_we_q;
    assign rf_sel_rd_o  = rf_sel_rd_q;
    assign rf_rd_o      = rf_rd_q;
    assign retire_o     = retire_q;
    assign misaligned_o = misaligned_q;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_WIDTH-1:0] instret_q;

    // Counts the registered retire pulse, so the count lags retire_o by one
    // cycle; natural overflow provides the wrap to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire_q) begin
            instret_q <= instret_q + CNT_WIDTH'(1);
        end
    end

    assign instret_o = instret_q;
`else
    assign instret_o = '0;
`endif

endmodule

// File: tb/tb_writeback.sv
// ----------------------------------------------------------------------------
// tb_writeback
// Scoreboard bench for the writeback stage. Expected commits are queued as
// stimulus is driven and compared when the DUT pulses its commit outputs.
// The counter width is shrunk so that wrap-around is reached quickly.
// ----------------------------------------------------------------------------
module tb_writeback;
    import risky_pkg::*;

    localparam int CNT_W = 4;
`ifdef WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             valid_i;
    logic             ready_o;
    logic [4:0]       opcode_i;
    logic [2:0]       funct3_i;
    logic [4:0]       rd_i;
    logic [31:0]      alu_result_i;
    logic [31:0]      pc_plus4_i;
    logic             mem_valid_i;
    logic [31:0]      mem_data_i;
    logic             rf_we_o;
    logic [4:0]       rf_sel_rd_o;
    logic [31:0]      rf_rd_o;
    logic             retire_o;
    logic             misaligned_o;
    logic [CNT_W-1:0] instret_o;

    writeback #(.XLEN(32), .CNT_WIDTH(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .opcode_i     (opcode_i),
        .funct3_i     (funct3_i),
        .rd_i         (rd_i),
        .alu_result_i (alu_result_i),
        .pc_plus4_i   (pc_plus4_i),
        .mem_valid_i  (mem_valid_i),
        .mem_data_i   (mem_data_i),
        .rf_we_o      (rf_we_o),
        .rf_sel_rd_o  (rf_sel_rd_o),
        .rf_rd_o      (rf_rd_o),
        .retire_o     (retire_o),
        .misaligned_o (misaligned_o),
        .instret_o    (instret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [4:0]  sel;
        logic [31:0] data;
        logic        retire;
        logic        mis;
        int          due;
    } exp_t;

    exp_t             sb_q[$];
    logic [CNT_W-1:0] exp_instret = '0;
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic expect_commit(input logic we, input logic [4:0] sel, input logic [31:0] data,
                                 input logic ret, input logic mis);
        exp_t e;
        e.we = we; e.sel = sel; e.data = data; e.retire = ret; e.mis = mis;
        e.due = cyc + 1;
        sb_q.push_back(e);
        if (ret) exp_instret++;
    endtask

    // Monitor: any commit pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (rf_we_o || retire_o || misaligned_o)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_commit", {61'd0, rf_we_o, retire_o, misaligned_o}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("commit_cycle", cyc, e.due);
                check("rf_we", rf_we_o, e.we);
                check("retire", retire_o, e.retire);
                check("misaligned", misaligned_o, e.mis);
                if (e.we) begin
                    check("rf_sel_rd", rf_sel_rd_o, e.sel);
                    check("rf_rd", rf_rd_o, e.data);
                end
            end
        end
    end

    // Non-load transfer; called at posedge+1 with the stage idle.
    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] pc4, input logic e_we, input logic [31:0] e_data);
        valid_i = 1'b1; opcode_i = op; funct3_i = 3'b000; rd_i = rd;
        alu_result_i = alu; pc_plus4_i = pc4;
        expect_commit(e_we, rd, e_data, 1'b1, 1'b0);
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    // Load transfer followed by 'waits' stall cycles and a memory response.
    task automatic load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] word, input int waits,
                        input logic e_we, input logic [31:0] e_data, input logic e_mis);
        valid_i = 1'b1; opcode_i = OP_LOAD; funct3_i = f3; rd_i = rd; alu_result_i = addr;
        mem_valid_i = 1'b1; mem_data_i = 32'hFFFF_FFFF;   // must be ignored here
        @(posedge clk); #1;
        mem_valid_i = 1'b0;
        for (int i = 0; i < waits; i++) begin
            check("ready_wait", ready_o, 1'b0);
            valid_i = 1'b1; opcode_i = OP_OP; rd_i = 5'd7; alu_result_i = 32'hBAD;  // ignored
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        mem_valid_i = 1'b1; mem_data_i = word;
        expect_commit(e_we, rd, e_data, !e_mis, e_mis);
        @(posedge clk); #1;
        mem_valid_i = 1'b0;
        check("ready_after_load", ready_o, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; opcode_i = '0; funct3_i = '0; rd_i = '0;
        alu_result_i = '0; pc_plus4_i = '0; mem_valid_i = 1'b0; mem_data_i = '0;
        idle(3);
        check("rst_ready", ready_o, 1'b1);
        check("rst_we", rf_we_o, 1'b0);
        check("rst_retire", retire_o, 1'b0);
        check("rst_mis", misaligned_o, 1'b0);
        check("rst_sel", rf_sel_rd_o, 5'd0);
        check("rst_rd", rf_rd_o, 32'd0);
        check("rst_instret", instret_o, '0);
        rst = 1'b0;
        idle(2);

        // Back-to-back ALU-class results, one per cycle.
        send(OP_OP,     5'd5, 32'h0000_1234, 32'h0, 1'b1, 32'h0000_1234);
        send(OP_OP_IMM, 5'd6, 32'hCAFE_0001, 32'h0, 1'b1, 32'hCAFE_0001);
        send(OP_LUI,    5'd7, 32'h1234_5000, 32'h0, 1'b1, 32'h1234_5000);
        send(OP_AUIPC,  5'd8, 32'h8000_0010, 32'h0, 1'b1, 32'h8000_0010);
        // Links take pc+4, x0 never written, no-write classes still retire.
        send(OP_JAL,    5'd1, 32'h0000_0F00, 32'h0000_0104, 1'b1, 32'h0000_0104);
        send(OP_JALR,   5'd2, 32'h0000_0F04, 32'h0000_0208, 1'b1, 32'h0000_0208);
        send(OP_OP,     5'd0, 32'h0000_0099, 32'h0, 1'b0, 32'h0);
        send(OP_STORE,  5'd3, 32'h0000_1000, 32'h0, 1'b0, 32'h0);
        send(OP_BRANCH, 5'd4, 32'h0000_2000, 32'h0, 1'b0, 32'h0);
        send(OP_SYSTEM, 5'd9, 32'h0000_3000, 32'h0, 1'b0, 32'h0);
        idle(3);
        check("instret_10", instret_o, CNT_EN ? exp_instret : '0);
        send(5'b11111,  5'd10, 32'h0000_4000, 32'h0, 1'b0, 32'h0);

        // Loads: byte/half lanes, sign vs zero extension, reserved funct3.
        load(F3_LB,  5'd10, 32'h0000_1003, 32'h80FF_0000, 3, 1'b1, 32'hFFFF_FF80, 1'b0);
        load(F3_LBU, 5'd11, 32'h0000_1003, 32'h80FF_0000, 3, 1'b1, 32'h0000_0080, 1'b0);
        load(F3_LH,  5'd12, 32'h0000_1002, 32'h80FF_0000, 1, 1'b1, 32'hFFFF_80FF, 1'b0);
        load(F3_LHU, 5'd13, 32'h0000_1002, 32'h80FF_0000, 0, 1'b1, 32'h0000_80FF, 1'b0);
        load(F3_LW,  5'd14, 32'h0000_1000, 32'hDEAD_BEEF, 2, 1'b1, 32'hDEAD_BEEF, 1'b0);
        load(3'b011, 5'd15, 32'h0000_1000, 32'h0BAD_F00D, 0, 1'b1, 32'h0BAD_F00D, 1'b0);
        load(F3_LB,  5'd16, 32'h0000_1001, 32'h1234_5678, 1, 1'b1, 32'h0000_0056, 1'b0);
        load(F3_LW,  5'd0,  32'h0000_1000, 32'h1111_2222, 0, 1'b0, 32'h0, 1'b0);
        // Misaligned loads are dropped.
        load(F3_LW,  5'd17, 32'h0000_1002, 32'h5555_AAAA, 1, 1'b0, 32'h0, 1'b1);
        load(F3_LH,  5'd18, 32'h0000_1001, 32'h5555_AAAA, 0, 1'b0, 32'h0, 1'b1);
        // Commit straight after a load response while ready is already high.
        send(OP_STORE, 5'd3, 32'h0000_1000, 32'h0, 1'b0, 32'h0);
        idle(3);
        check("instret_wrap", instret_o, CNT_EN ? exp_instret : '0);

        // Reset during WAIT_MEM discards the pending load.
        valid_i = 1'b1; opcode_i = OP_LOAD; funct3_i = F3_LW; rd_i = 5'd9; alu_result_i = 32'h100;
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("ready_pending", ready_o, 1'b0);
        idle(1);
        rst = 1'b1;
        #1;
        check("rst_wait_ready", ready_o, 1'b1);
        check("rst_wait_we", rf_we_o, 1'b0);
        check("rst_wait_sel", rf_sel_rd_o, 5'd0);
        check("rst_wait_rd", rf_rd_o, 32'd0);
        check("rst_wait_instret", instret_o, '0);
        exp_instret = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_valid_i = 1'b1; mem_data_i = 32'h0000_0055;
        @(posedge clk); #1;
        mem_valid_i = 1'b0;
        idle(2);
        check("post_rst_we", rf_we_o, 1'b0);
        check("post_rst_ready", ready_o, 1'b1);

        // Stage recovers normally after reset.
        send(OP_OP, 5'd20, 32'h0000_00AB, 32'h0, 1'b1, 32'h0000_00AB);
        idle(3);
        check("instret_final", instret_o, CNT_EN ? exp_instret : '0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
